// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings
// and the architectural zero register.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational EX-to-ID register dependency check against an in-flight load.
// Kept separate so forwarding logic can reuse the same comparator later.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd,
  input  logic       memread,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_used && (rs1 == rd);
  assign rs2_hit = rs2_used && (rs2 == rd);

  // A load targeting x0 never produces a value, so it can't create a hazard.
  assign lu = memread && (rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use bubble insertion and mispredict squash sequencing for the IF, IF/ID
// and ID/EX stages, plus saturating stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_ID_EX,
  input  logic             memread_ID_EX,
  input  logic             mispredict_EX,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] BCNT_INIT = 2'(LOAD_BUBBLES - 1);

  state_t           state_reg, state_next;
  logic [1:0]       bcnt_reg, bcnt_next;
  logic [CNT_W-1:0] stall_count_reg, flush_count_reg;
  logic             stall_inc, flush_inc;
  logic             lu;

  load_use_detect u_lu (
    .rs1      (rs1_ID),
    .rs2      (rs2_ID),
    .rs1_used (rs1_used_ID),
    .rs2_used (rs2_used_ID),
    .rd       (rd_ID_EX),
    .memread  (memread_ID_EX),
    .lu       (lu)
  );

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_clear = 1'b0;
    id_ex_clear = 1'b0;
    state_next  = state_reg;
    bcnt_next   = bcnt_reg;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
      state_next  = ST_RUN;
      bcnt_next   = 2'd0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (mispredict_EX) begin
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
            state_next  = ST_FLUSH;
            flush_inc   = 1'b1;
          end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_clear = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              bcnt_next  = BCNT_INIT;
              state_next = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (mispredict_EX) begin
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
            state_next  = ST_FLUSH;
            bcnt_next   = 2'd0;
            flush_inc   = 1'b1;
          end else begin
            // EX already holds a bubble here, so lu is deliberately ignored.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_clear = 1'b1;
            bcnt_next   = bcnt_reg - 2'd1;
            if (bcnt_reg == 2'd1) state_next = ST_RUN;
          end
        end
        ST_FLUSH: begin
          id_ex_clear = 1'b1;
          state_next  = ST_RUN;
        end
        default: begin
          state_next = ST_RUN;
          bcnt_next  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      bcnt_reg        <= 2'd0;
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      bcnt_reg  <= bcnt_next;
      if (stall_inc && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      if (flush_inc && (flush_count_reg != '1))
        flush_count_reg <= flush_count_reg + CNT_W'(1);
    end
  end

  assign busy        = !reset && (state_reg != ST_RUN);
  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a 1-bubble/4-bit-counter instance and a
// 3-bubble/16-bit-counter instance share stimulus and are checked separately.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_ID_EX = '0;
  logic       rs1_used_ID = 1'b0, rs2_used_ID = 1'b0;
  logic       memread_ID_EX = 1'b0, mispredict_EX = 1'b0;

  logic        pc_write1, if_id_write1, if_id_clear1, id_ex_clear1, busy1;
  logic [3:0]  stall1, flush1;
  logic        pc_write3, if_id_write3, if_id_clear3, id_ex_clear3, busy3;
  logic [15:0] stall3, flush3;

  int checks = 0;
  int failures = 0;

  // Packed view: {pc_write, if_id_write, if_id_clear, id_ex_clear, busy}
  logic [4:0] o1, o3;
  assign o1 = {pc_write1, if_id_write1, if_id_clear1, id_ex_clear1, busy1};
  assign o3 = {pc_write3, if_id_write3, if_id_clear3, id_ex_clear3, busy3};

  localparam logic [4:0] O_NORMAL   = 5'b11000;
  localparam logic [4:0] O_LU_RUN   = 5'b00010;
  localparam logic [4:0] O_STALL    = 5'b00011;
  localparam logic [4:0] O_MP_RUN   = 5'b11110;
  localparam logic [4:0] O_MP_STALL = 5'b11111;
  localparam logic [4:0] O_FLUSH    = 5'b11011;
  localparam logic [4:0] O_RESET    = 5'b00110;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_ID_EX(rd_ID_EX), .memread_ID_EX(memread_ID_EX),
    .mispredict_EX(mispredict_EX),
    .pc_write(pc_write1), .if_id_write(if_id_write1),
    .if_id_clear(if_id_clear1), .id_ex_clear(id_ex_clear1),
    .busy(busy1), .stall_count(stall1), .flush_count(flush1)
  );

  hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_ID_EX(rd_ID_EX), .memread_ID_EX(memread_ID_EX),
    .mispredict_EX(mispredict_EX),
    .pc_write(pc_write3), .if_id_write(if_id_write3),
    .if_id_clear(if_id_clear3), .id_ex_clear(id_ex_clear3),
    .busy(busy3), .stall_count(stall3), .flush_count(flush3)
  );

  // Apply one cycle of inputs just after the falling edge, settle, then return.
  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic u1, input logic u2,
                        input logic mp);
    @(negedge clk);
    memread_ID_EX = mr; rd_ID_EX = rd; rs1_ID = r1; rs2_ID = r2;
    rs1_used_ID = u1; rs2_used_ID = u2; mispredict_EX = mp;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load x5 in EX, ID reads x5 through rs1.
  task automatic lu_cycle(input logic mp);
    set_in(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, mp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    memread_ID_EX = 1'b0; mispredict_EX = 1'b0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (o1 !== O_RESET) begin failures++; $display("FAIL reset_out1 got=%b exp=%b", o1, O_RESET); end
    checks++; if (o3 !== O_RESET) begin failures++; $display("FAIL reset_out3 got=%b exp=%b", o3, O_RESET); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL reset_release1 got=%b exp=%b", o1, O_NORMAL); end
    checks++; if ({stall1, flush1} !== 8'h00) begin failures++; $display("FAIL reset_cnt1 got=%h exp=00", {stall1, flush1}); end
    checks++; if ({stall3, flush3} !== 32'h0) begin failures++; $display("FAIL reset_cnt3 got=%h exp=0", {stall3, flush3}); end
    $display("test_reset done t=%0t", $time);
  endtask

  task automatic test_load_use();
    do_reset();
    lu_cycle(1'b0);
    checks++; if (o1 !== O_LU_RUN) begin failures++; $display("FAIL lu1_detect got=%b exp=%b", o1, O_LU_RUN); end
    checks++; if (o3 !== O_LU_RUN) begin failures++; $display("FAIL lu3_detect got=%b exp=%b", o3, O_LU_RUN); end
    idle();
    checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL lu1_after got=%b exp=%b", o1, O_NORMAL); end
    checks++; if (stall1 !== 4'd1) begin failures++; $display("FAIL lu1_count got=%0d exp=1", stall1); end
    checks++; if (o3 !== O_STALL) begin failures++; $display("FAIL lu3_stall2 got=%b exp=%b", o3, O_STALL); end
    idle();
    checks++; if (o3 !== O_STALL) begin failures++; $display("FAIL lu3_stall3 got=%b exp=%b", o3, O_STALL); end
    idle();
    checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL lu3_after got=%b exp=%b", o3, O_NORMAL); end
    checks++; if (stall3 !== 16'd1) begin failures++; $display("FAIL lu3_count got=%0d exp=1", stall3); end
    $display("test_load_use done t=%0t", $time);
  endtask

  task automatic test_no_stall();
    do_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL nostall_x0 got=%b exp=%b", o1, O_NORMAL); end
    set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
    checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL nostall_rs2unused got=%b exp=%b", o1, O_NORMAL); end
    set_in(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL nostall_noload got=%b exp=%b", o1, O_NORMAL); end
    set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0);
    checks++; if (o1 !== O_LU_RUN) begin failures++; $display("FAIL stall_rs2used got=%b exp=%b", o1, O_LU_RUN); end
    idle();
    checks++; if (stall1 !== 4'd1) begin failures++; $display("FAIL nostall_count got=%0d exp=1", stall1); end
    $display("test_no_stall done t=%0t", $time);
  endtask

  task automatic test_mispredict_lu();
    do_reset();
    lu_cycle(1'b1);
    checks++; if (o1 !== O_MP_RUN) begin failures++; $display("FAIL mp_detect got=%b exp=%b", o1, O_MP_RUN); end
    lu_cycle(1'b1);
    checks++; if (o1 !== O_FLUSH) begin failures++; $display("FAIL mp_flush got=%b exp=%b", o1, O_FLUSH); end
    checks++; if (o3 !== O_FLUSH) begin failures++; $display("FAIL mp_flush3 got=%b exp=%b", o3, O_FLUSH); end
    idle();
    checks++; if (o1 !== O_NORMAL) begin failures++; $display("FAIL mp_after got=%b exp=%b", o1, O_NORMAL); end
    checks++; if (flush1 !== 4'd1) begin failures++; $display("FAIL mp_flushcnt got=%0d exp=1", flush1); end
    checks++; if (stall1 !== 4'd0) begin failures++; $display("FAIL mp_stallcnt got=%0d exp=0", stall1); end
    $display("test_mispredict_lu done t=%0t", $time);
  endtask

  task automatic test_stall_mispredict();
    do_reset();
    lu_cycle(1'b0);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (o3 !== O_MP_STALL) begin failures++; $display("FAIL stmp_detect got=%b exp=%b", o3, O_MP_STALL); end
    idle();
    checks++; if (o3 !== O_FLUSH) begin failures++; $display("FAIL stmp_flush got=%b exp=%b", o3, O_FLUSH); end
    idle();
    checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL stmp_after got=%b exp=%b", o3, O_NORMAL); end
    checks++; if ({stall3, flush3} !== {16'd1, 16'd1}) begin failures++; $display("FAIL stmp_counts got=%0d/%0d exp=1/1", stall3, flush3); end
    $display("test_stall_mispredict done t=%0t", $time);
  endtask

  task automatic test_reset_mid();
    do_reset();
    lu_cycle(1'b0);
    idle();
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (o3 !== O_RESET) begin failures++; $display("FAIL rstmid_stall got=%b exp=%b", o3, O_RESET); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (o3 !== O_NORMAL) begin failures++; $display("FAIL rstmid_release got=%b exp=%b", o3, O_NORMAL); end
    checks++; if (stall3 !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", stall3); end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); mispredict_EX = 1'b0; reset = 1'b1; #1;
    checks++; if (o1 !== O_RESET) begin failures++; $display("FAIL rstflush got=%b exp=%b", o1, O_RESET); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if ({o1, flush1} !== {O_NORMAL, 4'd0}) begin failures++; $display("FAIL rstflush_release got=%b/%0d exp=%b/0", o1, flush1, O_NORMAL); end
    $display("test_reset_mid done t=%0t", $time);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 15; i++) lu_cycle(1'b0);
    idle();
    checks++; if (stall1 !== 4'd15) begin failures++; $display("FAIL sat_15 got=%0d exp=15", stall1); end
    lu_cycle(1'b0);
    checks++; if (o1 !== O_LU_RUN) begin failures++; $display("FAIL sat_16_out got=%b exp=%b", o1, O_LU_RUN); end
    idle();
    checks++; if (stall1 !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall1); end
    $display("test_saturation done t=%0t", $time);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_mispredict_lu();
    test_stall_mispredict();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the enable and clear inputs of the IF stage, the IF/ID register and the ID/EX register. It sits beside the ID stage and compares the decoding instruction's source registers against the load currently in EX. It inserts a configurable number of load-use bubbles and sequences a two-cycle squash on a branch mispredict reported from EX. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- LOAD_BUBBLES, 1: number of bubbles inserted per load-use hazard; legal range 1..3.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- rs1_ID  in  5  rs1 field of the instruction in ID.
- rs2_ID  in  5  rs2 field of the instruction in ID.
- rs1_used_ID  in  1  ID instruction reads rs1.
- rs2_used_ID  in  1  ID instruction reads rs2.
- rd_ID_EX  in  5  destination register of the instruction in EX.
- memread_ID_EX  in  1  instruction in EX is a load.
- mispredict_EX  in  1  branch resolved in EX disagrees with the prediction.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_clear  out  1  IF/ID squash.
- id_ex_clear  out  1  ID/EX clear; inserts a bubble.
- busy  out  1  FSM is not in RUN.
- stall_count  out  CNT_W  number of load-use events.
- flush_count  out  CNT_W  number of mispredict events.

## Operation
- A load-use hazard (`lu`) is true when all of the following hold: memread_ID_EX=1, rd_ID_EX≠0, and either (rs1_used_ID and rs1_ID==rd_ID_EX) or (rs2_used_ID and rs2_ID==rd_ID_EX).
- The FSM has three states: RUN, STALL and FLUSH. A down-counter `bcnt` of 2 bits supports STALL.
- RUN, priority order:
  - mispredict_EX=1: if_id_clear=1, id_ex_clear=1, pc_write=1, if_id_write=1. Go to FLUSH. Increment flush_count.
  - else lu=1: pc_write=0, if_id_write=0, id_ex_clear=1. Increment stall_count. If LOAD_BUBBLES=1, stay in RUN. Otherwise set bcnt=LOAD_BUBBLES-1 and go to STALL.
  - else: pc_write=1, if_id_write=1, both clears 0.
- STALL: pc_write=0, if_id_write=0, id_ex_clear=1. Decrement bcnt. Return to RUN when bcnt==1. lu is not re-evaluated here, because EX holds a bubble. If mispredict_EX=1, take the RUN mispredict action, go to FLUSH and count it.
- FLUSH: pc_write=1, if_id_write=1, id_ex_clear=1, if_id_clear=0. Go to RUN. mispredict_EX and lu are ignored for this cycle.
- Counters saturate at all-ones and never wrap.
- busy = (state≠RUN).

## Timing
- Outputs are combinational from the state and current inputs, with no added latency. State, bcnt and counters update on the posedge of clk.
- While reset=1: pc_write=0, if_id_write=0, if_id_clear=1, id_ex_clear=1, busy=0. On the next edge: state=RUN, bcnt=0, both counters=0.
- Reset asserted mid-STALL or mid-FLUSH: the FSM returns to RUN on that edge and no counter increments.
- A load-use hazard costs LOAD_BUBBLES cycles with pc_write=0, counted from the detection cycle.
- A mispredict costs two squashed slots: IF/ID in the detection cycle and ID/EX in the FLUSH cycle.
- Simultaneous mispredict and lu in RUN: the mispredict wins. stall_count is unchanged.
- A counter at saturation with a new event holds its value.

## Structure
- A shared package/include `hazard_pkg` holds:
  - state encodings: RUN=2'd0, STALL=2'd1, FLUSH=2'd2;
  - the x0 register constant.
- One sub-module, `load_use_detect`, is the combinational `lu` comparator. It is reusable for future EX-to-ID forwarding checks.
- The top level contains the FSM, bcnt, the counters and the output decode.

## Test plan
- Load x5, then `add x6,x5,x1` (rs1_used=1), LOAD_BUBBLES=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_clear=1; next cycle normal; stall_count=1.
- Same sequence with LOAD_BUBBLES=3 -> three consecutive stall cycles, busy=1 for cycles 2–3, then RUN; stall_count=1.
- Load x0, or a load x5 followed by an ID instruction with rs2_ID=5 but rs2_used_ID=0 -> no stall; outputs stay normal.
- mispredict_EX=1 together with lu=1 in RUN -> that cycle if_id_clear=1 and id_ex_clear=1; next cycle FLUSH with id_ex_clear=1 and if_id_clear=0; flush_count=1, stall_count=0.
- reset=1 asserted during the second STALL cycle -> clears asserted and pc_write=0 while reset is high; after release, state=RUN and counters=0.
- Force stall_count to 2^CNT_W−1 (CNT_W=4: 15 events, then a 16th) -> stall_count stays at 15.
